// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_queue
//  Purpose  : Fetch-to-decode buffer. A DEPTH-entry circular queue sits in
//             front of a registered IF/ID output stage, so fetch can run
//             ahead while decode is stalled. An empty queue is bypassed so
//             fetch-to-decode latency stays at one cycle.
//  Revision : 1.0  initial release
// ============================================================================
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  // Derived from DEPTH; do not override.
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              if_valid,
  output logic              if_ready,
  // pipeline control
  input  logic [5:0]        stall,
  input  logic              flush,
  // decode side
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic [PTR_W:0]    q_count
);

  localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic [INST_W-1:0] r_mem_inst [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_id_pc;
  logic [INST_W-1:0] r_id_inst;
  logic              r_id_valid;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic w_ready;     // room in the queue
  logic w_push;      // fetch instruction accepted this cycle
  logic w_pop;       // output register loads this cycle
  logic w_nonempty;  // queue holds at least one entry
  logic w_bypass;    // accepted fetch goes straight to the output register
  logic w_enq;       // accepted fetch is written into the array
  logic w_deq;       // head entry moves into the output register

  // stall[0] and stall[5:3] belong to other stages and are not used here.
  logic w_unused_stall;
  assign w_unused_stall = ^{stall[5:3], stall[0]};

  // Readiness depends only on the registered count, so there is no
  // combinational path from stall/decode back to fetch.
  assign w_ready    = (r_count < C_DEPTH);
  assign w_nonempty = (r_count != '0);
  assign w_push     = if_valid & w_ready & ~stall[1];
  assign w_pop      = ~stall[2];
  assign w_bypass   = w_push & w_pop & ~w_nonempty;
  assign w_enq      = w_push & ~w_bypass;
  assign w_deq      = w_pop & w_nonempty;

  // --------------------------------------------------------------------------
  // Next-state computation
  // --------------------------------------------------------------------------
  logic [PTR_W:0]    w_count_next;
  logic [PTR_W-1:0]  w_head_next;
  logic [PTR_W-1:0]  w_tail_next;
  logic [ADDR_W-1:0] w_id_pc_next;
  logic [INST_W-1:0] w_id_inst_next;
  logic              w_id_valid_next;

  // Occupancy and pointer update; simultaneous enqueue/dequeue keeps count.
  always_comb begin
    w_count_next = r_count;
    w_head_next  = r_head;
    w_tail_next  = r_tail;
    if (w_enq) begin
      w_tail_next = r_tail + C_PTR_ONE;
    end
    if (w_deq) begin
      w_head_next = r_head + C_PTR_ONE;
    end
    if (w_enq && !w_deq) begin
      w_count_next = r_count + (PTR_W+1)'(1);
    end else if (w_deq && !w_enq) begin
      w_count_next = r_count - (PTR_W+1)'(1);
    end
  end

  // Output register source select: queue head, bypassed fetch, or bubble.
  always_comb begin
    w_id_pc_next    = r_id_pc;
    w_id_inst_next  = r_id_inst;
    w_id_valid_next = r_id_valid;
    if (w_pop) begin
      if (w_nonempty) begin
        w_id_pc_next    = r_mem_pc[r_head];
        w_id_inst_next  = r_mem_inst[r_head];
        w_id_valid_next = 1'b1;
      end else if (w_push) begin
        w_id_pc_next    = if_pc;
        w_id_inst_next  = if_inst;
        w_id_valid_next = 1'b1;
      end else begin
        w_id_pc_next    = '0;
        w_id_inst_next  = '0;
        w_id_valid_next = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Storage array: data only, no reset needed; written when an entry is
  // queued (a flush or reset cycle discards the write via the control path).
  always_ff @(posedge clk) begin
    if (w_enq && !rst && !flush) begin
      r_mem_pc[r_tail]   <= if_pc;
      r_mem_inst[r_tail] <= if_inst;
    end
  end

  // Pointers and count; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
    end
  end

  // IF/ID output register; flush overrides a decode stall.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
    end else begin
      r_id_pc    <= w_id_pc_next;
      r_id_inst  <= w_id_inst_next;
      r_id_valid <= w_id_valid_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign if_ready = w_ready;
  assign id_pc    = r_id_pc;
  assign id_inst  = r_id_inst;
  assign id_valid = r_id_valid;
  assign q_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_queue
//  Purpose  : Self-checking bench for if_id_queue. A queue-based reference
//             model predicts if_ready and the registered decode outputs for
//             directed scenarios followed by randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_id_queue;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;
  logic              if_ready;
  logic [5:0]        stall;
  logic              flush;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;
  logic [PTR_W:0]    q_count;

  if_id_queue #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .if_pc   (if_pc),
    .if_inst (if_inst),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .stall   (stall),
    .flush   (flush),
    .id_pc   (id_pc),
    .id_inst (id_inst),
    .id_valid(id_valid),
    .q_count (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: an ordered list of queued {pc,inst} plus the decode slot.
  logic [63:0]       m_q[$];
  logic [ADDR_W-1:0] m_pc;
  logic [INST_W-1:0] m_inst;
  logic              m_valid;
  bit                started = 0;

  // Fetch source: holds its instruction until accepted, then moves on by +4.
  logic [ADDR_W-1:0] src_pc;
  logic [INST_W-1:0] src_inst;

  task automatic step(input logic r, input logic fl, input logic v, input logic [5:0] st);
    bit acc;
    logic [63:0] e;
    rst = r; flush = fl; if_valid = v; stall = st;
    if_pc = src_pc; if_inst = src_inst;
    #1;
    if (started) chk("if_ready", {63'd0, if_ready}, {63'd0, (m_q.size() < DEPTH)});
    acc = 0;
    if (r || fl) begin
      m_q.delete();
      m_pc = '0; m_inst = '0; m_valid = 1'b0;
    end else begin
      acc = v && (m_q.size() < DEPTH) && !st[1];
      if (!st[2]) begin
        if (m_q.size() > 0) begin
          e = m_q.pop_front();
          m_pc = e[63:32]; m_inst = e[31:0]; m_valid = 1'b1;
          if (acc) m_q.push_back({src_pc, src_inst});
        end else if (acc) begin
          m_pc = src_pc; m_inst = src_inst; m_valid = 1'b1;
        end else begin
          m_pc = '0; m_inst = '0; m_valid = 1'b0;
        end
      end else if (acc) begin
        m_q.push_back({src_pc, src_inst});
      end
    end
    @(posedge clk);
    #1;
    started = 1;
    chk("id_pc",    {32'd0, id_pc},   {32'd0, m_pc});
    chk("id_inst",  {32'd0, id_inst}, {32'd0, m_inst});
    chk("id_valid", {63'd0, id_valid}, {63'd0, m_valid});
    chk("q_count",  {{(63-PTR_W){1'b0}}, q_count}, 64'(m_q.size()));
    @(negedge clk);
    if (acc) begin
      src_pc   = src_pc + 32'd4;
      src_inst = $urandom;
    end
  endtask

  logic [INST_W-1:0] seq_inst [3];
  logic [5:0]        rs;

  initial begin
    seq_inst[0] = 32'h3401_1100;
    seq_inst[1] = 32'h3402_0020;
    seq_inst[2] = 32'h0041_1825;
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; stall = '0;
    src_pc = '0; src_inst = '0; if_pc = '0; if_inst = '0;
    m_pc = '0; m_inst = '0; m_valid = 1'b0;

    // Reset then bypass: 1-cycle latency, queue stays empty.
    step(1, 0, 0, 6'b0);
    step(1, 0, 0, 6'b0);
    for (int i = 0; i < 3; i++) begin
      src_pc = 32'(i * 4); src_inst = seq_inst[i];
      step(0, 0, 1, 6'b0);
    end
    step(0, 0, 0, 6'b0);

    // Decode stall fills the queue; 5th/6th fetch refused until release.
    src_pc = 32'h1000; src_inst = $urandom;
    for (int i = 0; i < 6; i++) step(0, 0, 1, 6'b000100);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 6'b0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 6'b0);

    // Fetch stall drains three queued entries, then bubbles.
    src_pc = 32'h2000;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 6'b000100);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 6'b000010);

    // Continuous fetch with decode stall toggling: pointer wrap.
    step(1, 0, 0, 6'b0);
    src_pc = 32'h3000;
    for (int i = 0; i < 20; i++) step(0, 0, 1, (i % 2 == 0) ? 6'b000100 : 6'b000000);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 6'b0);

    // Flush with three queued entries and a concurrent fetch of 0x100.
    src_pc = 32'h4000;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 6'b000100);
    src_pc = 32'h100;
    step(0, 1, 1, 6'b000100);
    src_pc = 32'h200;
    step(0, 0, 1, 6'b0);
    step(0, 0, 0, 6'b0);

    // Reset mid-operation with two queued entries and a valid output.
    src_pc = 32'h5000;
    step(0, 0, 1, 6'b0);
    step(0, 0, 1, 6'b000100);
    step(0, 0, 1, 6'b000100);
    step(1, 0, 1, 6'b000100);
    src_pc = 32'h0;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 6'b0);

    // Randomized traffic, including ignored stall bits.
    src_pc = 32'h8000; src_inst = $urandom;
    for (int i = 0; i < 600; i++) begin
      rs = 6'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0), rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
`default_nettype wire
